// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM states and operand-class helpers.
package muldiv_pkg;

  localparam logic [2:0] MUL_OP    = 3'b000;
  localparam logic [2:0] MULH_OP   = 3'b001;
  localparam logic [2:0] MULHSU_OP = 3'b010;
  localparam logic [2:0] MULHU_OP  = 3'b011;
  localparam logic [2:0] DIV_OP    = 3'b100;
  localparam logic [2:0] DIVU_OP   = 3'b101;
  localparam logic [2:0] REM_OP    = 3'b110;
  localparam logic [2:0] REMU_OP   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Divide-class operation (DIV/DIVU/REM/REMU)
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // Remainder-class operation (REM/REMU)
  function automatic logic is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  // rs1 is treated as signed for everything except the fully unsigned ops
  function automatic logic rs1_signed(input logic [2:0] f);
    return (f != MULHU_OP) && (f != DIVU_OP) && (f != REMU_OP);
  endfunction

  // rs2 is signed only for the fully signed ops
  function automatic logic rs2_signed(input logic [2:0] f);
    return (f == MUL_OP) || (f == MULH_OP) || (f == DIV_OP) || (f == REM_OP);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(parameter int unsigned XLEN = 32);
  logic            valid_i;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output valid_i, funct3, rs1, rs2, kill,
                  input  busy, done, result);
  modport slave  (input  valid_i, funct3, rs1, rs2, kill,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider sharing one
// 2*XLEN accumulator, with early completion for the divide special cases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [2:0]          op;
  logic [CNT_W-1:0]    cnt;
  logic [XLEN-1:0]     mag;
  logic [2*XLEN-1:0]   acc;
  logic                neg;
  logic [XLEN-1:0]     result_q;

  logic                accept;
  logic                a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, special_val;
  logic [XLEN:0]       mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0]   mul_next, div_next, prod;
  logic [XLEN-1:0]     sel_div, div_val, fix_val;

  assign accept     = bus.valid_i && !bus.kill && (state == IDLE || state == DONE);
  assign bus.busy   = (state == CALC) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

  // Operand magnitudes and divide special-case detection at accept
  always_comb begin
    a_neg       = rs1_signed(bus.funct3) && bus.rs1[XLEN-1];
    b_neg       = rs2_signed(bus.funct3) && bus.rs2[XLEN-1];
    a_mag       = a_neg ? -bus.rs1 : bus.rs1;
    b_mag       = b_neg ? -bus.rs2 : bus.rs2;
    div_zero    = is_div(bus.funct3) && (bus.rs2 == '0);
    div_ovf     = is_div(bus.funct3) && !bus.funct3[0] &&
                  (bus.rs1 == MOST_NEG) && (bus.rs2 == '1);
    special_val = '0;
    if (div_zero)
      special_val = is_rem(bus.funct3) ? bus.rs1 : '1;
    else if (div_ovf)
      special_val = is_rem(bus.funct3) ? '0 : bus.rs1;
  end

  // One multiply add-shift step and one restoring divide step
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff     = rem_sh - {1'b0, mag};
    if (!diff[XLEN])
      div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Sign correction and high/low or quotient/remainder select
  always_comb begin
    prod    = neg ? -acc : acc;
    sel_div = is_rem(op) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    div_val = neg ? -sel_div : sel_div;
    if (is_div(op))
      fix_val = div_val;
    else if (op == MUL_OP)
      fix_val = prod[XLEN-1:0];
    else
      fix_val = prod[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      cnt      <= '0;
      mag      <= '0;
      acc      <= '0;
      neg      <= 1'b0;
      result_q <= '0;
    end else if (bus.kill) begin
      state <= IDLE;
    end else if (accept) begin
      op  <= bus.funct3;
      cnt <= '0;
      neg <= is_rem(bus.funct3) ? a_neg : (a_neg ^ b_neg);
      if (div_zero || div_ovf) begin
        result_q <= special_val;
        state    <= DONE;
      end else begin
        // Divide keeps the divisor in mag; multiply keeps the multiplicand
        mag   <= is_div(bus.funct3) ? b_mag : a_mag;
        acc   <= {{XLEN{1'b0}}, (is_div(bus.funct3) ? a_mag : b_mag)};
        state <= CALC;
      end
    end else begin
      case (state)
        CALC: begin
          acc <= is_div(op) ? div_next : mul_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          result_q <= fix_val;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit in the EX stage. Accepts one M-extension operation and computes it over XLEN+2 cycles with a shift-add multiplier or restoring divider. Stalls the pipeline via `busy` and presents a held result that feeds the M-extension input (i4) of the writeback-select mux. Special divide cases complete early with RISC-V mandated values.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two, at least 8.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `valid_i`  in  1: operation request, sampled on `clk`.
- `funct3`  in  3: operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`  in  XLEN: operand A (multiplicand or dividend).
- `rs2`  in  XLEN: operand B (multiplier or divisor).
- `kill`  in  1: synchronous flush of the in-flight operation.
- `busy`  out  1: the operation is in progress; the pipeline stalls.
- `done`  out  1: one-cycle pulse; `result` is valid.
- `result`  out  XLEN: result; held until the next accept.

## Operation
- States:
  - IDLE
  - CALC: XLEN iterations.
  - FIX: sign correction and high/low select.
  - DONE: `done`=1.
- Accept: `valid_i`=1 while in IDLE or DONE, with `kill`=0. Operands and `funct3` are latched at the accept edge.
- After accept, normal operations go to CALC with the counter at 0.
- Special divide cases go directly to DONE:
  - Divisor zero: DIV/DIVU give all-ones; REM/REMU give `rs1`.
  - Signed overflow (DIV/REM, `rs1`=most-negative, `rs2`=-1): DIV gives `rs1`; REM gives 0.
- Operand signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Signed operands are converted to magnitudes at accept. The result sign is recorded:
    - Product: XOR of the operand signs.
    - Quotient: XOR of the operand signs.
    - Remainder: the dividend sign.
- CALC, multiply: 2·XLEN-bit accumulator, one add-shift per cycle, LSB first.
- CALC, divide: one restoring subtract-shift per cycle, producing the quotient MSB first.
- The counter width is clog2(XLEN)+1. Leave CALC when the counter reaches XLEN-1.
- FIX:
  - Apply two's-complement negation if the recorded sign is set.
  - MUL selects the low XLEN bits; MULH/MULHSU/MULHU select the high XLEN bits.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Register the selected value into `result`.
- DONE: `done`=1 for exactly one cycle. Next state:
  - CALC, or DONE for a special case, on a new accept (back-to-back).
  - Otherwise IDLE.
- `busy` = (state==CALC or FIX). It is combinational from the state register.
- `kill`:
  - The next state is IDLE regardless of current state; `done` is never asserted for the killed operation.
  - `result` keeps its previous value.
  - If `kill` and `valid_i` are high together, `kill` wins and nothing is accepted.
- `valid_i` while `busy`=1: ignored. Upstream holds the instruction through the stall.
- Reset (any state, including mid-CALC):
  - State IDLE.
  - `busy`=0, `done`=0, `result`=0.
  - Counter, accumulators and sign flags cleared.

## Timing
- Normal operation accepted at edge E0:
  - `busy` is high from after E0 until edge E0+XLEN+1.
  - `done` is high in the cycle after edge E0+XLEN+1 (XLEN+2 cycles latency; 34 for XLEN=32).
- Special case: `done` is high in the cycle after E0; `busy` stays 0.
- `result` is stable from the `done` cycle until the next accept edge.
- A back-to-back accept in the DONE cycle starts CALC on that same edge. There is no bubble.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 localparams: MUL_OP … REMU_OP.
  - State enum: IDLE, CALC, FIX, DONE.
  - `is_div(funct3)` helper: funct3[2].
- Single module. Datapath and FSM are tightly coupled, so no sub-module.
- The funct3 encodings are shared with the decoder and the writeback-select logic.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) → `result`=0xFFFFFFEB. `done` exactly 34 cycles after accept; `busy` high for 33 cycles.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - Issue back-to-back in the DONE cycle and check there is no lost op.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; `done` one cycle after accept, `busy` never high.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Kill: assert `kill` 10 cycles into a DIV.
  - `busy`=0 next cycle, no `done`, `result` unchanged.
  - Then DIVU 9/3 → 3 on normal schedule.
  - `kill`+`valid_i` together → not accepted.
- Reset: assert `rst` mid-CALC (cycle 15), asynchronously between edges.
  - `busy`, `done` and `result` go to 0 immediately.
  - After release, MUL 3×4 → 12 with full latency.
